// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the ALU
// execution path.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 4;
  localparam int unsigned OP_W_DEF   = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SL  = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7
  } alu_op_e;

  localparam int unsigned OP_LAST = 32'(OP_SRA);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } exec_state_e;

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode legality decode: anything above OP_LAST is illegal.
module alu_op_check
  import alu_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op,
  output logic            legal
);

  assign legal = (32'(op) <= OP_LAST);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state read/execute/write-back sequencer for one reg-reg ALU instruction.
// Optional ALU_STATUS_FLAGS_EN adds registered flag_z / flag_n outputs.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [REG_AW-1:0] instr_rd,
  output logic [REG_AW-1:0] rb_read_reg1,
  output logic [REG_AW-1:0] rb_read_reg2,
  input  logic [DATA_W-1:0] rb_data_out1,
  input  logic [DATA_W-1:0] rb_data_out2,
  output logic [REG_AW-1:0] rb_write_reg,
  output logic [DATA_W-1:0] rb_write_data,
  output logic              rb_write_enable,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_result,
`ifdef ALU_STATUS_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  output logic              illegal
);

  exec_state_e       state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] opa_q, opb_q, result_q;
  logic              op_legal;

  alu_op_check #(.OP_W(OP_W)) u_op_check (
    .op    (op_q),
    .legal (op_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
`ifdef ALU_STATUS_FLAGS_EN
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && instr_valid) begin
        op_q  <= instr_op;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        rd_q  <= instr_rd;
      end
      // Operands are frozen here, so rd aliasing rs1/rs2 cannot corrupt them.
      if (state == ST_READ) begin
        opa_q <= rb_data_out1;
        opb_q <= rb_data_out2;
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
      end
`ifdef ALU_STATUS_FLAGS_EN
      if (state == ST_WB && op_legal) begin
        flag_z <= (result_q == '0);
        flag_n <= result_q[DATA_W-1];
      end
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    instr_ready     = 1'b0;
    rb_write_enable = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        rb_write_enable = op_legal;
        done            = 1'b1;
        illegal         = ~op_legal;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data outputs come straight from the latched registers and
  // therefore hold their last value outside their active state.
  assign rb_read_reg1  = rs1_q;
  assign rb_read_reg2  = rs2_q;
  assign alu_a         = opa_q;
  assign alu_b         = opb_q;
  assign alu_opcode    = op_q;
  assign rb_write_reg  = rd_q;
  assign rb_write_data = result_q;
  assign done_rd       = rd_q;
  assign done_result   = result_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench: behavioural register bank and ALU wrapped around alu_exec_ctrl.
module tb_alu_exec_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_valid, instr_ready;
  logic [3:0]  instr_op, instr_rs1, instr_rs2, instr_rd;
  logic [3:0]  rb_read_reg1, rb_read_reg2, rb_write_reg;
  logic [31:0] rb_data_out1, rb_data_out2, rb_write_data;
  logic        rb_write_enable;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_opcode;
  logic        done, illegal;
  logic [3:0]  done_rd;
  logic [31:0] done_result;
`ifdef ALU_STATUS_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  int unsigned vecs = 0;
  int unsigned errs = 0;

  alu_exec_ctrl #(.DATA_W(32), .REG_AW(4), .OP_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_rs1       (instr_rs1),
    .instr_rs2       (instr_rs2),
    .instr_rd        (instr_rd),
    .rb_read_reg1    (rb_read_reg1),
    .rb_read_reg2    (rb_read_reg2),
    .rb_data_out1    (rb_data_out1),
    .rb_data_out2    (rb_data_out2),
    .rb_write_reg    (rb_write_reg),
    .rb_write_data   (rb_write_data),
    .rb_write_enable (rb_write_enable),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_opcode      (alu_opcode),
    .alu_result      (alu_result),
    .done            (done),
    .done_rd         (done_rd),
    .done_result     (done_result),
`ifdef ALU_STATUS_FLAGS_EN
    .flag_z          (flag_z),
    .flag_n          (flag_n),
`endif
    .illegal         (illegal)
  );

  // Register bank: combinational read, write on rising edge; pre_* port preloads.
  logic [31:0] bank [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_reg = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (rb_write_enable) bank[rb_write_reg] <= rb_write_data;
    else if (pre_we)     bank[pre_reg] <= pre_data;
  end
  assign rb_data_out1 = bank[rb_read_reg1];
  assign rb_data_out2 = bank[rb_read_reg2];

  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (alu_opcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = alu_a << alu_b[4:0];
      4'd6: alu_result = alu_a >> alu_b[4:0];
      4'd7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  int unsigned wr_cnt = 0;
  int unsigned done_cnt = 0;
  always @(posedge clk) begin
    if (rb_write_enable) wr_cnt <= wr_cnt + 1;
    if (done)            done_cnt <= done_cnt + 1;
  end

  // Per-cycle observations captured by issue(); cycle 0 is the accept edge.
  logic        o_rdy1, o_rdy2, o_rdy3, o_rdy4;
  logic [3:0]  o_rr1, o_rr2, o_opc, o_drd;
  logic [31:0] o_a, o_b, o_dres;
  logic        o_done12, o_we12, o_done3, o_we3, o_ill3, o_done4;
  logic        o_timeout;

  task automatic preload(input logic [3:0] r, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_reg = r; pre_data = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    o_timeout = 1'b0;
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) o_timeout = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    o_rdy1 = instr_ready; o_rr1 = rb_read_reg1; o_rr2 = rb_read_reg2;
    o_done12 = done; o_we12 = rb_write_enable;
    @(negedge clk);
    o_rdy2 = instr_ready; o_a = alu_a; o_b = alu_b; o_opc = alu_opcode;
    o_done12 = o_done12 | done; o_we12 = o_we12 | rb_write_enable;
    @(negedge clk);
    o_rdy3 = instr_ready; o_done3 = done; o_we3 = rb_write_enable; o_ill3 = illegal;
    o_drd = done_rd; o_dres = done_result;
    @(negedge clk);
    o_rdy4 = instr_ready; o_done4 = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_rs1 = '0; instr_rs2 = '0; instr_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (instr_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    vecs++; if ({rb_write_enable, done, illegal} !== 3'b000) begin errs++; $display("FAIL rst_strobes: got %b want 000", {rb_write_enable, done, illegal}); end
    vecs++; if ({rb_read_reg1, rb_read_reg2, rb_write_reg, done_rd, alu_opcode} !== 20'h0) begin errs++; $display("FAIL rst_addr: got %h want 00000", {rb_read_reg1, rb_read_reg2, rb_write_reg, done_rd, alu_opcode}); end
    vecs++; if ({alu_a, alu_b, rb_write_data, done_result} !== 128'h0) begin errs++; $display("FAIL rst_data: got %h want 0", {alu_a, alu_b, rb_write_data, done_result}); end
`ifdef ALU_STATUS_FLAGS_EN
    vecs++; if ({flag_z, flag_n} !== 2'b00) begin errs++; $display("FAIL rst_flags: got %b want 00", {flag_z, flag_n}); end
`endif
    rst = 1'b0;
    for (int r = 0; r < 16; r++) preload(4'(r), 32'h0);
  endtask

  task automatic test_add();
    int unsigned w0;
    preload(4'd1, 32'd5);
    preload(4'd9, 32'd3);
    w0 = wr_cnt;
    issue(4'd0, 4'd1, 4'd9, 4'd3);
    vecs++; if (o_timeout) begin errs++; $display("FAIL add_accept: got timeout want ready"); end
    vecs++; if ({o_rr1, o_rr2} !== 8'h19) begin errs++; $display("FAIL add_read_addr: got %h want 19", {o_rr1, o_rr2}); end
    vecs++; if ({o_a, o_b} !== {32'd5, 32'd3}) begin errs++; $display("FAIL add_operands: got %h want %h", {o_a, o_b}, {32'd5, 32'd3}); end
    vecs++; if ({o_rdy1, o_rdy2, o_rdy3, o_rdy4} !== 4'b0001) begin errs++; $display("FAIL add_ready_seq: got %b want 0001", {o_rdy1, o_rdy2, o_rdy3, o_rdy4}); end
    vecs++; if ({o_done12, o_we12, o_done3, o_we3, o_ill3, o_done4} !== 6'b001100) begin errs++; $display("FAIL add_strobes: got %b want 001100", {o_done12, o_we12, o_done3, o_we3, o_ill3, o_done4}); end
    vecs++; if (o_drd !== 4'd3) begin errs++; $display("FAIL add_done_rd: got %0d want 3", o_drd); end
    vecs++; if (o_dres !== 32'd8) begin errs++; $display("FAIL add_done_result: got %h want 00000008", o_dres); end
    vecs++; if (bank[3] !== 32'd8) begin errs++; $display("FAIL add_r3: got %h want 00000008", bank[3]); end
    vecs++; if (wr_cnt - w0 !== 1) begin errs++; $display("FAIL add_write_count: got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_sub_negative();
    issue(4'd1, 4'd9, 4'd1, 4'd4);
    vecs++; if (o_dres !== 32'hFFFFFFFE) begin errs++; $display("FAIL sub_done_result: got %h want fffffffe", o_dres); end
    vecs++; if (bank[4] !== 32'hFFFFFFFE) begin errs++; $display("FAIL sub_r4: got %h want fffffffe", bank[4]); end
    vecs++; if (o_opc !== 4'd1) begin errs++; $display("FAIL sub_alu_opcode: got %0d want 1", o_opc); end
`ifdef ALU_STATUS_FLAGS_EN
    vecs++; if ({flag_z, flag_n} !== 2'b01) begin errs++; $display("FAIL sub_flags: got zn=%b want 01", {flag_z, flag_n}); end
`endif
  endtask

  task automatic test_sra_hazard();
    preload(4'd2, 32'h80000000);
    preload(4'd5, 32'd1);
    issue(4'd7, 4'd2, 4'd5, 4'd2);
    vecs++; if (o_a !== 32'h80000000) begin errs++; $display("FAIL sra_operand_a: got %h want 80000000", o_a); end
    vecs++; if (o_dres !== 32'hC0000000) begin errs++; $display("FAIL sra_done_result: got %h want c0000000", o_dres); end
    vecs++; if (bank[2] !== 32'hC0000000) begin errs++; $display("FAIL sra_r2: got %h want c0000000", bank[2]); end
  endtask

  task automatic test_illegal();
    logic [31:0] snap [16];
    int unsigned w0;
    int unsigned diff;
    preload(4'd6, 32'h00001234);
    @(negedge clk);
    for (int r = 0; r < 16; r++) snap[r] = bank[r];
    w0 = wr_cnt;
    issue(4'd10, 4'd1, 4'd9, 4'd6);
    vecs++; if ({o_done3, o_ill3} !== 2'b11) begin errs++; $display("FAIL ill_done_illegal: got %b want 11", {o_done3, o_ill3}); end
    vecs++; if (wr_cnt - w0 !== 0) begin errs++; $display("FAIL ill_write_count: got %0d want 0", wr_cnt - w0); end
    vecs++; if (o_dres !== 32'hDEADBEEF) begin errs++; $display("FAIL ill_done_result: got %h want deadbeef", o_dres); end
    diff = 0;
    for (int r = 0; r < 16; r++) if (bank[r] !== snap[r]) diff++;
    vecs++; if (diff !== 0) begin errs++; $display("FAIL ill_regs_unchanged: got %0d changed want 0", diff); end
`ifdef ALU_STATUS_FLAGS_EN
    vecs++; if ({flag_z, flag_n} !== 2'b01) begin errs++; $display("FAIL ill_flags_hold: got zn=%b want 01", {flag_z, flag_n}); end
`endif
  endtask

  task automatic test_back_to_back();
    int unsigned w0, d0;
    logic [3:0] rdy;
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd2; instr_rs1 = 4'd1; instr_rs2 = 4'd9; instr_rd = 4'd10;
    @(posedge clk);
    #1 instr_op = 4'd3; instr_rs1 = 4'd9; instr_rs2 = 4'd3; instr_rd = 4'd11;
    @(negedge clk); rdy[0] = instr_ready;
    @(negedge clk); rdy[1] = instr_ready;
    @(negedge clk); rdy[2] = instr_ready;
    vecs++; if ({done, done_rd, done_result} !== {1'b1, 4'd10, 32'd1}) begin errs++; $display("FAIL b2b_first_done: got %b/%0d/%h want 1/10/00000001", done, done_rd, done_result); end
    @(negedge clk); rdy[3] = instr_ready;
    vecs++; if (rdy !== 4'b1000) begin errs++; $display("FAIL b2b_ready_c1_c4: got %b want 1000 (c4..c1)", rdy); end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    vecs++; if ({instr_ready, rb_read_reg1, rb_read_reg2} !== {1'b0, 4'd9, 4'd3}) begin errs++; $display("FAIL b2b_second_accept: got %b/%0d/%0d want 0/9/3", instr_ready, rb_read_reg1, rb_read_reg2); end
    repeat (2) @(negedge clk);
    vecs++; if ({done, done_rd, done_result} !== {1'b1, 4'd11, 32'd11}) begin errs++; $display("FAIL b2b_second_done: got %b/%0d/%h want 1/11/0000000b", done, done_rd, done_result); end
    repeat (3) @(negedge clk);
    vecs++; if ((done_cnt - d0 !== 2) || (wr_cnt - w0 !== 2)) begin errs++; $display("FAIL b2b_counts: got done=%0d wr=%0d want 2/2", done_cnt - d0, wr_cnt - w0); end
    vecs++; if ({bank[10], bank[11]} !== {32'd1, 32'd11}) begin errs++; $display("FAIL b2b_regs: got %h/%h want 00000001/0000000b", bank[10], bank[11]); end
  endtask

  task automatic test_reset_mid_op();
    int unsigned w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd4; instr_rs1 = 4'd1; instr_rs2 = 4'd9; instr_rd = 4'd12;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++; if ({instr_ready, done, rb_write_enable} !== 3'b100) begin errs++; $display("FAIL rstmid_after: got rdy/done/we=%b want 100", {instr_ready, done, rb_write_enable}); end
    repeat (4) @(negedge clk);
    vecs++; if ((done_cnt - d0 !== 0) || (wr_cnt - w0 !== 0)) begin errs++; $display("FAIL rstmid_counts: got done=%0d wr=%0d want 0/0", done_cnt - d0, wr_cnt - w0); end
    vecs++; if (bank[12] !== 32'h0) begin errs++; $display("FAIL rstmid_r12: got %h want 00000000", bank[12]); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_negative();
    test_sra_hazard();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execution controller that turns one register-to-register ALU instruction (opcode, rs1, rs2, rd) into a complete read, execute and write-back sequence. It drives the read ports of `register_bank`, feeds the `alu`, and writes the result back through the bank's write port. It is the initiator that sits in front of the bank/ALU pair and stands in for the hand-driven stimulus used to exercise them. Upstream is a simple valid/ready instruction source, which will later be the fetch/decode stage.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 4, register address width (16 registers)
- OP_W, 4, opcode width

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr_op  in  OP_W  ALU opcode
- instr_rs1 / instr_rs2  in  REG_AW  source registers
- instr_rd  in  REG_AW  destination register
- rb_read_reg1 / rb_read_reg2  out  REG_AW  to bank read_reg1/read_reg2
- rb_data_out1 / rb_data_out2  in  DATA_W  from bank data_out1/data_out2 (combinational read)
- rb_write_reg  out  REG_AW  to bank write_reg
- rb_write_data  out  DATA_W  to bank write_data
- rb_write_enable  out  1  to bank write_enable
- alu_a / alu_b  out  DATA_W  to ALU A/B
- alu_opcode  out  OP_W  to ALU opcode
- alu_result  in  DATA_W  from ALU result
- done  out  1  one-cycle completion pulse
- done_rd  out  REG_AW  destination of the completed instruction
- done_result  out  DATA_W  value written (or that would have been written)
- illegal  out  1  qualifies `done`: the opcode was illegal and nothing was written

## Operation
- The FSM has four states: IDLE → READ → EXEC → WB → IDLE.
- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid & instr_ready`, latch op, rs1, rs2 and rd, then go to READ.
- **READ**
  - Drive `rb_read_reg1`=rs1 and `rb_read_reg2`=rs2.
  - Capture `rb_data_out1/2` into operand registers at the clock edge.
- **EXEC**
  - Drive `alu_a`/`alu_b` from the operand registers and `alu_opcode` from the latched op.
  - Capture `alu_result` into the result register at the clock edge.
- **WB**
  - Legal op: `rb_write_enable`=1, `rb_write_reg`=rd, `rb_write_data`=result.
  - Always pulse `done` for this cycle, with `done_rd`=rd and `done_result`=result.
  - Illegal op: `rb_write_enable` stays 0 and `illegal`=1.
- **Legal opcodes** are 0–7: ADD, SUB, AND, OR, XOR, SL, SRL, SRA. Opcodes 8–15 are illegal and are still sequenced through EXEC.
- **Arithmetic** is performed entirely by the ALU. The controller does no arithmetic; all values are modulo 2^DATA_W.
- **rd equal to rs1 or rs2** is safe, because operands are captured in READ, before WB.
- **Write strobe:** `rb_write_enable` is high for exactly one cycle per legal instruction and never outside WB.
- **Address outputs** hold their last values outside their active states; consumers must qualify them by state or by enable.

## Timing
- Reset values:
  - state=IDLE, `instr_ready`=1
  - `rb_write_enable`=0, `done`=0, `illegal`=0
  - all address, data and opcode outputs = 0
- Latency: accept edge = cycle 0; READ = cycle 1; EXEC = cycle 2; WB/`done` = cycle 3; `instr_ready` is high again in cycle 4.
- Throughput: one instruction per 4 cycles.
- `instr_ready` is 0 during READ, EXEC and WB. `instr_valid` held during those states is ignored and not consumed.
- `done_rd` and `done_result` are valid only while `done`=1.
- Reset in any state takes effect at the next edge: the FSM returns to IDLE and the in-flight instruction is dropped. Reset asserted during WB suppresses nothing already written at that edge, and no further write occurs.

## Configuration
- `ALU_STATUS_FLAGS_EN` defined:
  - Adds outputs `flag_z` (result==0) and `flag_n` (result[DATA_W-1]).
  - Both are registered at WB of legal ops, hold until the next legal WB, and reset to 0.
- Undefined: the ports and logic are absent.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants OP_ADD=0 … OP_SRA=7 and OP_LAST=7
  - FSM state encoding
  - default widths
- One sub-module is natural: `alu_op_check`, a combinational legality decode (op ≤ OP_LAST). It is shared later with decode.
- The bank and ALU are instantiated outside this block. Only the bench connects them together with this block.

## Test plan
- **ADD.** Preload R1=5, R9=3, then issue ADD rs1=1 rs2=9 rd=3. Required: write R3=8 in cycle 3; `done`=1, `done_rd`=3, `done_result`=8.
- **SUB, negative result.** Issue SUB with R9=3, R1=5 (rs1=9, rs2=1), rd=4. Required: R4=0xFFFFFFFE; with `ALU_STATUS_FLAGS_EN` defined, `flag_n`=1 and `flag_z`=0.
- **SRA.** Preload R2=0x80000000, then SRA rs1=2 rd=2. Required: R2=0xC0000000, and the rd==rs1 hazard is handled correctly.
- **Illegal opcode.** Issue opcode 4'b1010. Required: `done`=1, `illegal`=1, `rb_write_enable` never asserted, all registers unchanged.
- **Back-to-back.** Hold `instr_valid` high with two instructions queued. Required: the second is accepted exactly in cycle 4; `instr_ready`=0 in cycles 1–3.
- **Reset mid-operation.** Assert `rst` during EXEC. Required: no write, no `done`, `instr_ready`=1 in the cycle after reset deasserts.
